key_token_fifo: RTL and testbench
=================================

# key_token_fifo

Sits between the keypad scan decoder and the stack calculator core. Watches the decoder's 4-bit key code, its new-token flag and the raw keypad rows. Turns each debounced physical key press into exactly one token, regardless of how long the key is held. Tokens are buffered in a small first-word-fall-through FIFO, which the calculator core drains with a valid/ready handshake.

## Interface
- STABLE_CYCLES, 2_000_000: cycles a key code must stay unchanged before it is accepted (20 ms at 100 MHz); must be ≥ 2.
- RELEASE_CYCLES, 500_000: cycles of Row == 4'hF needed to declare a key released; must exceed one full 4-column scan (400_000).
- DEPTH, 8: FIFO entries; power of two, ≥ 2.
- AW, 3: log2(DEPTH).
- clk  in  1  100 MHz system clock; single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- DecodeOut  in  4  key code from the decoder.
- DecoderState  in  1  decoder new-token flag (sticky once set).
- Row  in  4  raw keypad row lines, active-low.
- token_out  out  4  FIFO head key code.
- token_is_op  out  1  1 when token_out ≥ 4'hA (operator key A–F); 0 for digits 0–9.
- token_valid  out  1  FIFO non-empty.
- token_ready  in  1  consumer accepts head this cycle.
- fifo_count  out  AW+1  number of stored tokens.
- overflow  out  1  sticky; a token was dropped because the FIFO was full.

## Operation
- FSM states: ARMED, QUALIFY, HELD. Reset state is ARMED.
- A "press sample" is any cycle with Row != 4'hF.
- Release counter rel_cnt:
  - Cleared on any press sample.
  - Otherwise increments, saturating at RELEASE_CYCLES.
  - "released" means rel_cnt == RELEASE_CYCLES.
- ARMED:
  - On a press sample with DecoderState == 1: go to QUALIFY, load candidate <= DecodeOut, clear stab_cnt.
  - Otherwise stay.
- QUALIFY:
  - If DecodeOut != candidate: candidate <= DecodeOut, stab_cnt <= 0. This absorbs the decoder's 8-cycle lag after the column drive.
  - Else stab_cnt increments.
  - When stab_cnt reaches STABLE_CYCLES-1 with no mismatch: push candidate and go to HELD.
  - If released before that: return to ARMED with no push.
  - Release has priority over acceptance in the same cycle.
- HELD:
  - Ignore DecodeOut changes.
  - When released: go to ARMED.
  - A key held indefinitely yields exactly one token.
- FIFO:
  - DEPTH × 4-bit memory with AW+1-bit read and write pointers.
  - Empty when pointers are equal; full when they differ only in the MSB.
- Pop: occurs when token_valid && token_ready.
- Push:
  - Accepted if not full, or if full and a pop happens in the same cycle.
  - Otherwise the token is dropped and overflow <= 1.
  - overflow clears only on reset.
- Simultaneous push and pop: fifo_count is unchanged and pointers wrap modulo 2^(AW+1).
- token_is_op is combinational from token_out. token_out is meaningful only while token_valid == 1.

## Timing
- Reset values:
  - token_out = 0, token_is_op = 0, token_valid = 0, fifo_count = 0, overflow = 0.
  - FSM = ARMED; candidate, stab_cnt, rel_cnt and both pointers = 0.
- Asserting rst_n low mid-operation clears all state immediately. Buffered tokens are lost.
- Press-to-push latency is STABLE_CYCLES cycles after the last DecodeOut change.
- Push-to-visible latency:
  - token_valid rises the cycle after a push into an empty FIFO.
  - fifo_count updates the cycle after a push or pop.
- Head advance: token_out shows the next entry the cycle after a pop.
- A pop of the last entry drops token_valid the following cycle.
- token_valid never depends combinationally on token_ready.
- Same cycle as acceptance: a press sample resets rel_cnt only. It does not block acceptance.

## Test plan
Use STABLE_CYCLES=16, RELEASE_CYCLES=40, DEPTH=4, token_ready=1 unless stated.
- Single press: DecoderState=1, DecodeOut=4'h5, Row pulses 4'hB once per 20 cycles for 200 cycles, then Row=4'hF.
  - Required: exactly one token 4'h5 with token_is_op=0, token_valid high for one cycle.
  - Required: no second token while the key is held.
- Bounce: DecodeOut toggles 4'h3/4'h6 every 5 cycles for 60 cycles, then settles at 4'hA.
  - Required: one token 4'hA, token_is_op=1, pushed 16 cycles after the last change.
- Short tap: press sample, then Row=4'hF for 40 cycles before 16 stable cycles elapse.
  - Required: no token; FSM back in ARMED.
- Overflow: token_ready=0; five distinct press/release cycles with codes 1, 2, 3, 4, 5.
  - Required: fifo_count=4 and overflow=1.
  - Then raise token_ready: tokens 1, 2, 3, 4 are read out in order, and overflow stays 1.
- Full with simultaneous pop: FIFO full; a push coincides with a pop.
  - Required: push accepted, fifo_count stays 4, overflow stays 0.
  - Required: order preserved across pointer wrap.
- Reset mid-qualify: rst_n pulsed low at stab_cnt=10 with 2 tokens queued.
  - Required: all outputs 0 immediately and asynchronously; no token from the aborted press.

Source files
------------

// File: rtl/key_token_fifo.sv
// Turns each debounced keypad press into exactly one 4-bit token and buffers
// the tokens in a first-word-fall-through FIFO for the calculator core.
module key_token_fifo #(
  parameter int STABLE_CYCLES  = 2_000_000,
  parameter int RELEASE_CYCLES = 500_000,
  parameter int DEPTH          = 8,
  parameter int AW             = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    DecodeOut,
  input  logic          DecoderState,
  input  logic [3:0]    Row,
  output logic [3:0]    token_out,
  output logic          token_is_op,
  output logic          token_valid,
  input  logic          token_ready,
  output logic [AW:0]   fifo_count,
  output logic          overflow,
  output logic [1:0]    fsm_state
);

  localparam int SW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int RW = $clog2(RELEASE_CYCLES + 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] REL_MAX   = RW'(RELEASE_CYCLES);

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    QUALIFY = 2'd1,
    HELD    = 2'd2
  } state_t;

  state_t        state;
  logic [3:0]    candidate;
  logic [SW-1:0] stab_cnt;
  logic [RW-1:0] rel_cnt;
  logic [3:0]    mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  logic press;
  logic released;
  logic push_req;
  logic push_ok;
  logic pop;
  logic full;

  assign press    = (Row != 4'hF);
  assign released = (rel_cnt == REL_MAX);

  // Release wins over acceptance: a key that is already let go never qualifies.
  assign push_req = (state == QUALIFY) && !released &&
                    (DecodeOut == candidate) && (stab_cnt == STAB_LAST);

  // Handshake: a token transfers on any cycle where token_valid && token_ready;
  // token_valid depends only on stored pointers, never on token_ready.
  assign pop     = token_valid && token_ready;
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ok = push_req && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rel_cnt <= '0;
    end else if (press) begin
      rel_cnt <= '0;
    end else if (!released) begin
      rel_cnt <= rel_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARMED;
      candidate <= '0;
      stab_cnt  <= '0;
    end else begin
      case (state)
        ARMED: begin
          if (press && DecoderState) begin
            state     <= QUALIFY;
            candidate <= DecodeOut;
            stab_cnt  <= '0;
          end
        end
        QUALIFY: begin
          if (released) begin
            state <= ARMED;
          end else if (DecodeOut != candidate) begin
            candidate <= DecodeOut;
            stab_cnt  <= '0;
          end else if (stab_cnt == STAB_LAST) begin
            state <= HELD;
          end else begin
            stab_cnt <= stab_cnt + 1'b1;
          end
        end
        HELD: begin
          if (released) begin
            state <= ARMED;
          end
        end
        default: state <= ARMED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= candidate;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_req && !push_ok) begin
        overflow <= 1'b1;
      end
    end
  end

  assign token_out   = mem[rd_ptr[AW-1:0]];
  assign token_is_op = (token_out >= 4'hA);
  assign token_valid = (wr_ptr != rd_ptr);
  assign fifo_count  = wr_ptr - rd_ptr;
  assign fsm_state   = state;

endmodule

// File: tb/tb_key_token_fifo.sv
// Bench for key_token_fifo: press/bounce/tap/overflow/wrap/reset scenarios with
// a token scoreboard that checks every popped token against the expected queue.
module tb_key_token_fifo;

  localparam int STABLE  = 16;
  localparam int RELEASE = 40;
  localparam int DEPTH   = 4;
  localparam int AW      = 2;

  logic          clk;
  logic          rst_n;
  logic [3:0]    decode_out;
  logic          decoder_state;
  logic [3:0]    row;
  logic [3:0]    token_out;
  logic          token_is_op;
  logic          token_valid;
  logic          token_ready;
  logic [AW:0]   fifo_count;
  logic          overflow;
  logic [1:0]    fsm_state;

  logic [3:0] exp_q[$];
  int n_tests;
  int n_fail;
  int n_pops;
  int valid_cycles;
  int pops_before;
  int valid_before;

  key_token_fifo #(
    .STABLE_CYCLES (STABLE),
    .RELEASE_CYCLES(RELEASE),
    .DEPTH         (DEPTH),
    .AW            (AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .DecodeOut   (decode_out),
    .DecoderState(decoder_state),
    .Row         (row),
    .token_out   (token_out),
    .token_is_op (token_is_op),
    .token_valid (token_valid),
    .token_ready (token_ready),
    .fifo_count  (fifo_count),
    .overflow    (overflow),
    .fsm_state   (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_token_out"}, 32'(token_out), 32'h0);
    check({tag, "_is_op"}, 32'(token_is_op), 32'h0);
    check({tag, "_valid"}, 32'(token_valid), 32'h0);
    check({tag, "_count"}, 32'(fifo_count), 32'h0);
    check({tag, "_overflow"}, 32'(overflow), 32'h0);
    check({tag, "_fsm"}, 32'(fsm_state), 32'h0);
  endtask

  // press, hold long enough to qualify, then release fully
  task automatic press_key(input logic [3:0] code);
    decode_out = code;
    row        = 4'hB;
    tick(STABLE + 4);
    row = 4'hF;
    tick(RELEASE + 5);
  endtask

  // scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n && token_valid) begin
      valid_cycles++;
      if (token_ready) begin
        n_pops++;
        if (exp_q.size() == 0) begin
          check("sb_extra_token", 32'(exp_q.size()), 32'h1);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          check("sb_data", 32'(token_out), 32'(e));
          check("sb_is_op", 32'(token_is_op), 32'(e >= 4'hA));
        end
      end
    end
  end

  initial begin
    n_tests = 0; n_fail = 0; n_pops = 0; valid_cycles = 0;
    rst_n = 1'b0;
    decode_out = 4'h0;
    decoder_state = 1'b0;
    row = 4'hF;
    token_ready = 1'b1;
    #3;
    check_idle("reset");
    tick(2);
    rst_n = 1'b1;
    tick(RELEASE + 10);

    // single press with scanning row pulses
    pops_before = n_pops; valid_before = valid_cycles;
    decoder_state = 1'b1;
    decode_out = 4'h5;
    exp_q.push_back(4'h5);
    for (int i = 0; i < 200; i++) begin
      row = (i % 20 == 0) ? 4'hB : 4'hF;
      tick(1);
    end
    row = 4'hF;
    tick(RELEASE + 20);
    check("single_pops", 32'(n_pops - pops_before), 32'd1);
    check("single_valid_len", 32'(valid_cycles - valid_before), 32'd1);
    check("single_fsm_armed", 32'(fsm_state), 32'd0);

    // bounce then settle on an operator key
    row = 4'hB;
    for (int i = 0; i < 12; i++) begin
      decode_out = (i % 2 == 1) ? 4'h6 : 4'h3;
      tick(5);
    end
    decode_out = 4'hA;
    exp_q.push_back(4'hA);
    tick(STABLE);
    check("bounce_not_early", 32'(token_valid), 32'd0);
    tick(1);
    check("bounce_push_time", 32'(token_valid), 32'd1);
    check("bounce_head", 32'(token_out), 32'hA);
    check("bounce_is_op", 32'(token_is_op), 32'd1);
    row = 4'hF;
    tick(RELEASE + 10);
    check("bounce_fsm_armed", 32'(fsm_state), 32'd0);

    // short tap: released before the code ever stays stable long enough
    pops_before = n_pops;
    decode_out = 4'h7;
    row = 4'hB;
    tick(1);
    row = 4'hF;
    for (int i = 0; i < 12; i++) begin
      decode_out = (i % 2 == 1) ? 4'h2 : 4'h7;
      tick(4);
      if (i == 2) check("tap_qualify", 32'(fsm_state), 32'd1);
    end
    tick(5);
    check("tap_fsm_armed", 32'(fsm_state), 32'd0);
    check("tap_no_token", 32'(n_pops - pops_before), 32'd0);
    check("tap_count", 32'(fifo_count), 32'd0);

    // overflow: five presses into a four-entry FIFO
    token_ready = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c <= DEPTH) exp_q.push_back(4'(c));
      press_key(4'(c));
    end
    check("ovf_count", 32'(fifo_count), 32'(DEPTH));
    check("ovf_flag", 32'(overflow), 32'd1);
    pops_before = n_pops;
    token_ready = 1'b1;
    tick(10);
    check("ovf_drain_pops", 32'(n_pops - pops_before), 32'(DEPTH));
    check("ovf_drain_count", 32'(fifo_count), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // full FIFO with push and pop in the same cycle, across pointer wrap
    rst_n = 1'b0;
    tick(1);
    check("rst2_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    tick(2);
    for (int c = 1; c <= 4; c++) begin
      exp_q.push_back(4'(c));
      press_key(4'(c));
    end
    token_ready = 1'b0;
    for (int c = 9; c <= 12; c++) begin
      exp_q.push_back(4'(c));
      press_key(4'(c));
    end
    check("wrap_full", 32'(fifo_count), 32'(DEPTH));
    decode_out = 4'hD;
    row = 4'hB;
    exp_q.push_back(4'hD);
    tick(STABLE);
    token_ready = 1'b1;
    tick(1);
    token_ready = 1'b0;
    check("simul_count", 32'(fifo_count), 32'(DEPTH));
    check("simul_overflow", 32'(overflow), 32'd0);
    check("simul_fsm_held", 32'(fsm_state), 32'd2);
    row = 4'hF;
    token_ready = 1'b1;
    tick(RELEASE + 10);
    check("wrap_drained", 32'(fifo_count), 32'd0);

    // reset mid-qualify with tokens queued
    token_ready = 1'b0;
    press_key(4'h7);
    press_key(4'h8);
    check("mid_queued", 32'(fifo_count), 32'd2);
    decode_out = 4'hE;
    row = 4'hB;
    tick(11);
    check("mid_qualify", 32'(fsm_state), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    row = 4'hF;
    decoder_state = 1'b0;
    tick(2);
    rst_n = 1'b1;
    pops_before = n_pops;
    token_ready = 1'b1;
    tick(RELEASE + 20);
    check("mid_no_token", 32'(n_pops - pops_before), 32'd0);
    check("mid_valid", 32'(token_valid), 32'd0);

    check("sb_all_seen", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
